board_io_ctrl: RTL and testbench
================================

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 Parameter N_BTN, 3, number of push-button channels (>=1).
REQ-002 Parameter N_DIG, 4, number of 7-segment digits scanned (>=1).
REQ-003 Parameter DB_CYCLES, 650000, stable-input cycles required to accept a button change (>=2).
REQ-004 Parameter SCAN_CYCLES, 65000, clk cycles each digit stays active (>=2).
REQ-005 Parameter REP_DELAY, 32500000, held cycles before first auto-repeat (used only with BTN_REPEAT_EN).
REQ-006 Parameter REP_RATE, 6500000, cycles between auto-repeats (used only with BTN_REPEAT_EN).
REQ-007 clk  input  1  system clock, all logic rising-edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 btn_raw  input  N_BTN  unsynchronised button pins, 1 = pressed.
REQ-010 digit_val  input  4*N_DIG  hex nibble per digit, digit i at [4i+3:4i].
REQ-011 digit_en  input  N_DIG  1 = digit lit, 0 = blanked.
REQ-012 dp_in  input  N_DIG  decimal point per digit, 1 = lit.
REQ-013 btn_level  output  N_BTN  debounced button state.
REQ-014 btn_press  output  N_BTN  one-cycle pulse per accepted press (and repeat).
REQ-015 btn_release  output  N_BTN  one-cycle pulse per accepted release.
REQ-016 an  output  N_DIG  digit anodes, active-low, one-hot.
REQ-017 seg  output  7  segments, active-low, seg[0]=a .. seg[6]=g.
REQ-018 dp  output  1  decimal point, active-low.

Function
REQ-019 Each btn_raw bit SHALL pass a 2-flop synchroniser before debounce.
REQ-020 Per channel, while synchronised input != btn_level, a counter SHALL increment; on reaching DB_CYCLES-1 btn_level SHALL toggle and the counter clear.
REQ-021 Any cycle where synchronised input == btn_level SHALL clear the counter (bounce restarts qualification).
REQ-022 Latency raw edge -> btn_level change SHALL be exactly 2+DB_CYCLES cycles for a clean edge.
REQ-023 btn_press/btn_release SHALL assert for exactly the cycle in which btn_level is first seen 1/0 after its toggle.
REQ-024 Channels SHALL be independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-025 A scan counter SHALL count 0..SCAN_CYCLES-1; at wrap the digit index SHALL advance, N_DIG-1 wrapping to 0.
REQ-026 an, seg, dp SHALL be registered, reflecting the current index one cycle after index update; an[idx]=0, all other bits 1.
REQ-027 seg SHALL be the hex decode of digit_val for idx (0->7'b1000000, 1->7'b1111001, 8->7'b0000000, F->7'b0001110); digit_en[idx]=0 SHALL force seg=7'h7F and dp=1 while an still scans.
REQ-028 dp SHALL equal ~dp_in[idx] when digit_en[idx]=1.
REQ-029 digit_val/digit_en/dp_in changes SHALL appear on outputs within one cycle, no glitch beyond the registered output.

Reset
REQ-030 rst assertion SHALL immediately force: synchronisers, btn_level, btn_press, btn_release = 0; all counters = 0; idx = 0; an = all 1; seg = 7'h7F; dp = 1.
REQ-031 After rst deassert, first an activation (an[0]=0) SHALL occur on the first clk edge.
REQ-032 rst mid-qualification or mid-repeat SHALL discard progress; a still-held button re-qualifies from zero.

Configuration
REQ-033 Macro BTN_REPEAT_EN defined: while btn_level=1, btn_press SHALL re-pulse REP_DELAY cycles after the accepted press, then every REP_RATE cycles until release; release clears the repeat counter.
REQ-034 Macro BTN_REPEAT_EN undefined: exactly one btn_press per accepted press; REP_* parameters unused, no repeat logic synthesised.

Structure
REQ-035 Package board_io_pkg SHALL hold the hex-to-segment table/function and SEG_BLANK (7'h7F) constant.
REQ-036 Sub-module btn_debounce (one channel: synchroniser, debounce, pulses, optional repeat) SHALL be generated N_BTN times; counter widths via $clog2 of the parameters.

Verification (DB_CYCLES=8, SCAN_CYCLES=4, N_DIG=4, REP_DELAY=20, REP_RATE=5)
REQ-037 Clean press btn_raw[0] 0->1 held -> btn_level[0]=1 and one btn_press[0] pulse exactly 10 cycles later; release -> btn_release[0] 10 cycles after.
REQ-038 Bounce: btn_raw[1] toggling every 5 cycles for 40 cycles -> btn_level[1] stays 0, no pulses.
REQ-039 digit_val=16'h8F10, digit_en=4'hF -> an cycles 1110,1101,1011,0111 each 4 cycles, seg 1000000,1111001,0001110,0000000.
REQ-040 digit_en=4'b1011 -> during an=1011 seg=7'h7F, dp=1.
REQ-041 BTN_REPEAT_EN, btn_raw[2] held 50 cycles after acceptance -> press pulses at +0, +20, +25, +30, ... +50; none with macro undefined.
REQ-042 rst pulse mid-scan and mid-debounce -> outputs at reset values same cycle; scan restarts at an=1110.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board I/O controller.
// Holds the active-low 7-segment hex table and the blank pattern.
package board_io_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low segments, bit 0 = a .. bit 6 = g.
   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce, press/release
// pulses, and auto-repeat when BTN_REPEAT_EN is defined.
// Ports: clk, rst (async, active-high), raw_i (pin, 1 = pressed),
//        level_o (debounced), press_o / release_o (one-cycle pulses).
module btn_debounce
   import board_io_pkg::*;
#(
   parameter int DB_CYCLES = 650000,
   parameter int REP_DELAY = 32500000,
   parameter int REP_RATE  = 6500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             mismatch, toggle, rep_hit;

`ifdef BTN_REPEAT_EN
   localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
   localparam int REP_W = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REP_DELAY - 1);
   localparam logic [REP_W-1:0] RATE_LAST = REP_W'(REP_RATE - 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_fast_q, rep_fast_d;

   // Counts only while held; the accepted press restarts it at zero.
   always_comb begin
      rep_cnt_d  = '0;
      rep_fast_d = 1'b0;
      rep_hit    = 1'b0;
      if (level_q && !toggle) begin
         rep_fast_d = rep_fast_q;
         rep_cnt_d  = rep_cnt_q + REP_W'(1);
         if ((!rep_fast_q && rep_cnt_q == DLY_LAST) ||
             ( rep_fast_q && rep_cnt_q == RATE_LAST)) begin
            rep_hit    = 1'b1;
            rep_cnt_d  = '0;
            rep_fast_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt_q  <= '0;
         rep_fast_q <= 1'b0;
      end else begin
         rep_cnt_q  <= rep_cnt_d;
         rep_fast_q <= rep_fast_d;
      end
   end
`else
   assign rep_hit = 1'b0;
`endif

   // Any cycle of agreement drops the count, so bounces restart it.
   always_comb begin
      mismatch = sync2_q ^ level_q;
      toggle   = mismatch && (cnt_q == DB_LAST);
      cnt_d    = (mismatch && !toggle) ? cnt_q + CNT_W'(1) : '0;
      level_d  = level_q ^ toggle;
      press_d  = (toggle && !level_q) || rep_hit;
      rel_d    = toggle && level_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: N_BTN debounced buttons and an N_DIG digit
// multiplexed 7-segment driver. Optional macro: BTN_REPEAT_EN.
// Ports: clk, rst (async, active-high), btn_raw, digit_val, digit_en,
//        dp_in -> btn_level, btn_press, btn_release, an, seg, dp
//        (an/seg/dp active-low).
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int N_BTN       = 3,
   parameter int N_DIG       = 4,
   parameter int DB_CYCLES   = 650000,
   parameter int SCAN_CYCLES = 65000,
   parameter int REP_DELAY   = 32500000,
   parameter int REP_RATE    = 6500000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_BTN-1:0]   btn_raw,
   input  logic [4*N_DIG-1:0] digit_val,
   input  logic [N_DIG-1:0]   digit_en,
   input  logic [N_DIG-1:0]   dp_in,
   output logic [N_BTN-1:0]   btn_level,
   output logic [N_BTN-1:0]   btn_press,
   output logic [N_BTN-1:0]   btn_release,
   output logic [N_DIG-1:0]   an,
   output logic [6:0]         seg,
   output logic               dp
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DB_CYCLES (DB_CYCLES),
         .REP_DELAY (REP_DELAY),
         .REP_RATE  (REP_RATE)
      ) u_btn (
         .clk       (clk),
         .rst       (rst),
         .raw_i     (btn_raw[i]),
         .level_o   (btn_level[i]),
         .press_o   (btn_press[i]),
         .release_o (btn_release[i])
      );
   end

   localparam int SCAN_W = $clog2(SCAN_CYCLES);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [N_DIG-1:0]  an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              scan_wrap;
   logic [3:0]        nib;

   // Outputs decode idx_q, so they trail the index by one cycle and
   // the first edge after reset already lights digit 0.
   always_comb begin
      scan_wrap  = (scan_cnt_q == SCAN_LAST);
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
      idx_d      = idx_q;
      if (scan_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      an_d        = '1;
      an_d[idx_q] = 1'b0;
      nib         = digit_val[4*int'(idx_q) +: 4];
      seg_d       = SEG_BLANK;
      dp_d        = 1'b1;
      if (digit_en[idx_q]) begin
         seg_d = hex2seg(nib);
         dp_d  = ~dp_in[idx_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with small debounce/scan parameters.
// Expected values are hand-derived; repeat checks follow BTN_REPEAT_EN.
module tb_board_io_ctrl;

   logic        clk;
   logic        rst;
   logic [2:0]  btn_raw;
   logic [15:0] digit_val;
   logic [3:0]  digit_en;
   logic [3:0]  dp_in;
   logic [2:0]  btn_level;
   logic [2:0]  btn_press;
   logic [2:0]  btn_release;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_assert = 0;
   int n_fail   = 0;

   board_io_ctrl #(
      .N_BTN       (3),
      .N_DIG       (4),
      .DB_CYCLES   (8),
      .SCAN_CYCLES (4),
      .REP_DELAY   (20),
      .REP_RATE    (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .digit_val   (digit_val),
      .digit_en    (digit_en),
      .dp_in       (dp_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .an          (an),
      .seg         (seg),
      .dp          (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [3:0] an_tab [4];
   logic [6:0] seg_tab [4];
   logic       dp_tab [4];
   logic       rep_on;
   logic       exp_p;
   logic       seen;

   initial begin
      an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0001110, 7'b0000000};
      dp_tab  = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef BTN_REPEAT_EN
      rep_on = 1'b1;
`else
      rep_on = 1'b0;
`endif
      rst       = 1'b1;
      btn_raw   = 3'b000;
      digit_val = 16'h8F10;
      digit_en  = 4'hF;
      dp_in     = 4'b0101;
      #2;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
      chk("rst_lvl", 32'(btn_level), 32'h0);
      chk("rst_prs", 32'(btn_press), 32'h0);
      chk("rst_rel", 32'(btn_release), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 4; k++) begin
            step(1);
            chk($sformatf("scan_an_%0d_%0d", d, k), 32'(an),
                32'(an_tab[d]));
            chk($sformatf("scan_seg_%0d_%0d", d, k), 32'(seg),
                32'(seg_tab[d]));
            chk($sformatf("scan_dp_%0d_%0d", d, k), 32'(dp),
                32'(dp_tab[d]));
         end
      end
      step(1);
      chk("scan_wrap", 32'(an), 32'hE);

      digit_en = 4'b1011;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         step(1);
         if (an === 4'b1011) seen = 1'b1;
      end
      chk("blank_seen", 32'(seen), 32'h1);
      chk("blank_seg", 32'(seg), 32'h7F);
      chk("blank_dp", 32'(dp), 32'h1);
      step(4);
      chk("blank_nxt_an", 32'(an), 32'h7);
      chk("blank_nxt_seg", 32'(seg), 32'h00);
      digit_en = 4'hF;

      btn_raw[0] = 1'b1;
      step(9);
      chk("p0_lvl_early", 32'(btn_level), 32'h0);
      chk("p0_prs_early", 32'(btn_press), 32'h0);
      step(1);
      chk("p0_lvl", 32'(btn_level), 32'h1);
      chk("p0_prs", 32'(btn_press), 32'h1);
      step(1);
      chk("p0_prs_once", 32'(btn_press), 32'h0);
      chk("p0_lvl_hold", 32'(btn_level), 32'h1);
      btn_raw[0] = 1'b0;
      step(9);
      chk("r0_lvl_early", 32'(btn_level), 32'h1);
      chk("r0_rel_early", 32'(btn_release), 32'h0);
      step(1);
      chk("r0_lvl", 32'(btn_level), 32'h0);
      chk("r0_rel", 32'(btn_release), 32'h1);
      step(1);
      chk("r0_rel_once", 32'(btn_release), 32'h0);

      for (int k = 0; k < 40; k++) begin
         if (k % 5 == 0) btn_raw[1] = ~btn_raw[1];
         step(1);
         chk($sformatf("bnc_%0d", k),
             32'({btn_level[1], btn_press[1], btn_release[1]}), 32'h0);
      end
      btn_raw[1] = 1'b0;
      step(12);
      chk("bnc_end", 32'(btn_level), 32'h0);

      btn_raw[2] = 1'b1;
      step(10);
      chk("p2_prs", 32'(btn_press), 32'h4);
      chk("p2_lvl", 32'(btn_level), 32'h4);
      for (int k = 1; k <= 50; k++) begin
         step(1);
         exp_p = rep_on && (k >= 20) && ((k - 20) % 5 == 0);
         chk($sformatf("rep_%0d", k), 32'(btn_press), 32'({exp_p, 2'b00}));
      end
      btn_raw[2] = 1'b0;
      step(10);
      chk("r2_rel", 32'(btn_release), 32'h4);
      chk("r2_lvl", 32'(btn_level), 32'h0);
      step(10);
      chk("r2_quiet", 32'(btn_press), 32'h0);

      btn_raw = 3'b011;
      step(10);
      chk("multi_prs", 32'(btn_press), 32'h3);
      chk("multi_lvl", 32'(btn_level), 32'h3);

      btn_raw = 3'b111;
      step(5);
      rst = 1'b1;
      #1;
      chk("mrst_an", 32'(an), 32'hF);
      chk("mrst_seg", 32'(seg), 32'h7F);
      chk("mrst_dp", 32'(dp), 32'h1);
      chk("mrst_lvl", 32'(btn_level), 32'h0);
      chk("mrst_prs", 32'(btn_press), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step(1);
      chk("mrst_an_first", 32'(an), 32'hE);
      step(3);
      chk("mrst_an_hold", 32'(an), 32'hE);
      step(1);
      chk("mrst_an_next", 32'(an), 32'hD);
      step(4);
      chk("mrst_lvl_early", 32'(btn_level), 32'h0);
      step(1);
      chk("mrst_lvl", 32'(btn_level), 32'h7);
      chk("mrst_prs", 32'(btn_press), 32'h7);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
